flash_op_arbiter: RTL



---
 rtl/flash_op_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/flash_op_arbiter.sv
// Round-robin arbiter sharing one NAND page engine between NREQ flash requesters.
// Define FLASH_ARB_TIMEOUT_EN to add a RUN-state watchdog and the sticky timeout_err output.
module flash_op_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ROW_W  = 24
`ifdef FLASH_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TO_W   = 24,
  parameter int unsigned TO_CYC = 4_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [ROW_W*NREQ-1:0] req_addr_row,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [1:0]            done_status,
  output logic                  busy,
  output logic                  en_op,
  output logic [1:0]            op_code,
  output logic [ROW_W-1:0]      op_addr_row,
  input  logic                  end_op,
  input  logic [1:0]            op_success
`ifdef FLASH_ARB_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [1:0]         status_q, status_d;
  logic               en_q, en_d;
  logic [1:0]         code_q, code_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   rr_q, rr_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   slot_idx;
  logic [1:0]         pick_op;
  logic [ROW_W-1:0]   pick_row;
  logic [NREQ-1:0]    pick_onehot;

`ifdef FLASH_ARB_TIMEOUT_EN
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               to_err_q, to_err_d;
`endif

  // Descending scan so the slot closest to rr_q (smallest offset) is the last writer.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    slot_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      slot_idx = IDX_W'((32'(rr_q) + 32'(i)) % NREQ);
      if (req[slot_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = slot_idx;
      end
    end
  end

  always_comb begin
    pick_op     = '0;
    pick_row    = '0;
    pick_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDX_W'(i) == pick_idx) begin
        pick_op        = req_op[2*i +: 2];
        pick_row       = req_addr_row[ROW_W*i +: ROW_W];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    status_d = status_q;
    en_d     = en_q;
    code_d   = code_q;
    row_d    = row_q;
    g_d      = g_q;
    rr_d     = rr_q;
`ifdef FLASH_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    to_err_d = to_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          g_d     = pick_idx;
          grant_d = pick_onehot;
          code_d  = pick_op;
          row_d   = pick_row;
          if (pick_op == 2'd3) begin
            // Illegal op never reaches the engine.
            status_d = 2'd2;
            done_d   = pick_onehot;
            state_d  = StDone;
          end else begin
            en_d    = 1'b1;
            state_d = StRun;
`ifdef FLASH_ARB_TIMEOUT_EN
            to_cnt_d = '0;
`endif
          end
        end
      end
      StRun: begin
        if (end_op) begin
          en_d     = 1'b0;
          status_d = (op_success == 2'd1) ? 2'd1 : 2'd2;
          done_d   = grant_q;
          state_d  = StDone;
        end
`ifdef FLASH_ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TO_CYC - 1)) begin
          en_d     = 1'b0;
          status_d = 2'd3;
          done_d   = grant_q;
          to_err_d = 1'b1;
          state_d  = StDone;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      StDone: begin
        grant_d = '0;
        rr_d    = (32'(g_q) == NREQ - 1) ? '0 : g_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      done_q   <= '0;
      status_q <= '0;
      en_q     <= 1'b0;
      code_q   <= '0;
      row_q    <= '0;
      g_q      <= '0;
      rr_q     <= '0;
`ifdef FLASH_ARB_TIMEOUT_EN
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      status_q <= status_d;
      en_q     <= en_d;
      code_q   <= code_d;
      row_q    <= row_d;
      g_q      <= g_d;
      rr_q     <= rr_d;
`ifdef FLASH_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign done_status = status_q;
  assign busy        = (state_q != StIdle);
  assign en_op       = en_q;
  assign op_code     = code_q;
  assign op_addr_row = row_q;
`ifdef FLASH_ARB_TIMEOUT_EN
  assign timeout_err = to_err_q;
`endif

endmodule
